// File: rtl/note_pkg.sv
// Shared packet layout and envelope state encoding for the note envelope stage.
package note_pkg;

  localparam int PACKET_SIZE = 24;
  localparam int TUNE_MSB    = 23;
  localparam int TUNE_LSB    = 8;
  localparam int VOL_MSB     = 7;

  typedef logic [PACKET_SIZE-1:0] packetType;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } envState_t;

endpackage

// File: rtl/envelope_channel.sv
// One track's ADSR state machine, 8.8 envelope level and volume scaling.
module envelope_channel
  import note_pkg::*;
#(
  parameter logic [15:0] ATTACK_INC    = 16'd64,
  parameter logic [15:0] DECAY_DEC     = 16'd16,
  parameter logic [7:0]  SUSTAIN_LEVEL = 8'd192,
  parameter logic [15:0] RELEASE_DEC   = 16'd8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wgEn,
  input  packetType note_in,
  output packetType env_out,
  output logic      active
);

  localparam logic [15:0] SUSTAIN_ENV = {SUSTAIN_LEVEL, 8'h00};

  envState_t   state, state_next, eff_state;
  logic [15:0] env, env_next;
  logic [15:0] tune_lat, tune_next;
  logic [7:0]  vol_lat, vol_next;

  logic [15:0] tune_in;
  logic [7:0]  vol_in;
  logic        note_on, gated, retrigger;
  logic [16:0] att_sum, dec_diff, rel_diff;

  logic [7:0]  env_hi;
  logic [8:0]  prod_top;
  logic [7:0]  vol_shaped;

  assign tune_in   = note_in[TUNE_MSB:TUNE_LSB];
  assign vol_in    = note_in[VOL_MSB:0];
  assign note_on   = (|tune_in) & (|vol_in);
  assign gated     = (state == ATTACK) || (state == DECAY) || (state == SUSTAIN);
  assign retrigger = note_on & ((state == IDLE) || (state == RELEASE) || (tune_in != tune_lat));

  // Bit 16 is carry for the add and borrow for the subtracts.
  assign att_sum  = {1'b0, env} + {1'b0, ATTACK_INC};
  assign dec_diff = {1'b0, env} - {1'b0, DECAY_DEC};
  assign rel_diff = {1'b0, env} - {1'b0, RELEASE_DEC};

  // The level update runs on the state chosen by this tick's gate decision,
  // so a fresh note already climbs on its first tick.
  always_comb begin
    state_next = state;
    eff_state  = state;
    env_next   = env;
    tune_next  = tune_lat;
    vol_next   = vol_lat;
    if (wgEn) begin
      if (retrigger) begin
        eff_state = ATTACK;
        tune_next = tune_in;
        vol_next  = vol_in;
      end else if (!note_on && gated) begin
        eff_state = RELEASE;
      end else if (note_on && gated) begin
        vol_next = vol_in;
      end
      state_next = eff_state;
      case (eff_state)
        ATTACK: begin
          if (att_sum[16] || (att_sum[15:0] == 16'hFFFF)) begin
            env_next   = 16'hFFFF;
            state_next = DECAY;
          end else begin
            env_next = att_sum[15:0];
          end
        end
        DECAY: begin
          if (dec_diff[16] || (dec_diff[15:0] < SUSTAIN_ENV)) begin
            env_next   = SUSTAIN_ENV;
            state_next = SUSTAIN;
          end else begin
            env_next = dec_diff[15:0];
          end
        end
        SUSTAIN: env_next = env;
        RELEASE: begin
          if (rel_diff[16] || (rel_diff[15:0] == 16'h0000)) begin
            env_next   = 16'h0000;
            state_next = IDLE;
          end else begin
            env_next = rel_diff[15:0];
          end
        end
        default: env_next = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      env      <= 16'h0000;
      tune_lat <= 16'h0000;
      vol_lat  <= 8'h00;
    end else begin
      state    <= state_next;
      env      <= env_next;
      tune_lat <= tune_next;
      vol_lat  <= vol_next;
    end
  end

  // Only product bits [15:7] matter: the high byte plus the rounding bit.
  assign env_hi   = env[15:8];
  assign prod_top = 9'(({8'h00, env_hi} * {8'h00, vol_lat}) >> 7);

  always_comb begin
    vol_shaped = vol_lat;
    if (env_hi != 8'hFF) begin
      vol_shaped = prod_top[8:1] + {7'b0, prod_top[0] & ~(&prod_top[8:1])};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_out <= '0;
      active  <= 1'b0;
    end else begin
      env_out <= (state == IDLE) ? '0 : {tune_lat, vol_shaped};
      active  <= (state != IDLE);
    end
  end

endmodule

// File: rtl/note_envelope.sv
// Per-track ADSR envelope stage between the SPI receiver and the tone generators.
module note_envelope
  import note_pkg::*;
#(
  parameter int          NUM_TRACKS    = 4,
  parameter logic [15:0] ATTACK_INC    = 16'd64,
  parameter logic [15:0] DECAY_DEC     = 16'd16,
  parameter logic [7:0]  SUSTAIN_LEVEL = 8'd192,
  parameter logic [15:0] RELEASE_DEC   = 16'd8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wgEn,
  input  packetType             notePackets [NUM_TRACKS],
  output packetType             envPackets  [NUM_TRACKS],
  output logic [NUM_TRACKS-1:0] envActive
);

  for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_track
    envelope_channel #(
      .ATTACK_INC   (ATTACK_INC),
      .DECAY_DEC    (DECAY_DEC),
      .SUSTAIN_LEVEL(SUSTAIN_LEVEL),
      .RELEASE_DEC  (RELEASE_DEC)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .wgEn   (wgEn),
      .note_in(notePackets[i]),
      .env_out(envPackets[i]),
      .active (envActive[i])
    );
  end

endmodule
